// File: rtl/booth_radix4_accumulator.sv
`default_nettype none
// ============================================================================
// Module  : booth_radix4_accumulator
// Purpose : Sequential radix-4 Booth multiplier for signed operands. It works
//           with an external encoder that returns each digit in the same cycle.
// Rev     : 1.0  initial release
// ============================================================================
module booth_radix4_accumulator #(
    parameter int N = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic [2:0]       booth_x,
    input  logic [2:0]       booth_y,
    output logic [2*N-1:0]   product,
    output logic             done,
    output logic             err
);

    localparam int CW = (N / 2 > 1) ? $clog2(N / 2) : 1;
    localparam logic [CW-1:0]  LAST_IDX = CW'(N / 2 - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [2*N-1:0] PP_ONE   = (2 * N)'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [N:0]     bsh_q, bsh_d;
    logic [2*N-1:0] msh_q, msh_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [2*N-1:0] product_q, product_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           err_q, err_d;

    logic           accept;
    logic           running;
    logic           dig_neg, dig_one, dig_two;
    logic [2*N-1:0] mag;
    logic [2*N-1:0] pp;
    logic [2*N-1:0] acc_sum;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (cnt_q == LAST_IDX) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        ready   = (state_q == S_IDLE);
        done    = (state_q == S_DONE);
        running = (state_q == S_RUN);
        booth_x = running ? bsh_q[2:0] : 3'b000;
    end

    assign accept  = ready & start;
    assign product = product_q;
    assign err     = err_q;

    // An illegal digit (one and two both set) falls through the 'one' branch.
    assign dig_neg = booth_y[2];
    assign dig_one = booth_y[1];
    assign dig_two = booth_y[0];

    always_comb begin
        mag = '0;
        if (dig_one) begin
            mag = msh_q;
        end else if (dig_two) begin
            mag = msh_q << 1;
        end
    end

    assign pp      = dig_neg ? ((~mag) + PP_ONE) : mag;
    assign acc_sum = acc_q + pp;

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        bsh_d     = bsh_q;
        msh_d     = msh_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        err_d     = err_q;
        if (accept) begin
            bsh_d = {b, 1'b0};
            msh_d = {{N{a[N-1]}}, a};
            acc_d = '0;
            cnt_d = '0;
            err_d = 1'b0;
        end else if (running) begin
            bsh_d = {{2{bsh_q[N]}}, bsh_q[N:2]};
            msh_d = msh_q << 2;
            acc_d = acc_sum;
            cnt_d = cnt_q + CNT_ONE;
            if (dig_one && dig_two) begin
                err_d = 1'b1;
            end
            // The result register is loaded with the final sum on the way out of RUN.
            if (cnt_q == LAST_IDX) begin
                product_d = acc_sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bsh_q     <= '0;
            msh_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            err_q     <= 1'b0;
        end else begin
            bsh_q     <= bsh_d;
            msh_q     <= msh_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            err_q     <= err_d;
        end
    end

endmodule
`default_nettype wire
